rfbw_wb_queue: RTL and testbench
================================

Name: rfbw_wb_queue

Overview:
- Writeback queue directly upstream of the general-purpose register file.
- Collects up to three results per cycle from the execution units and buffers them in program order in a circular FIFO.
- Drives the register file's three write channels (wr0..wr2, wa0..wa2, i0..i2, ip0..ip2), issuing up to three writes per cycle.
- Oldest entry always goes on channel 0 and youngest on channel 2, which matches the register file's same-address priority (ch2 > ch1 > ch0).

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- VALW, 64: result width; equals the package Value width.
- IPW, 32: instruction-address width; equals the package CodeAddress width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all queued entries.
- stall  in  1  register file not accepting; suppresses dequeue.
- s_valid  in  3  per-source result valid; source 0 is oldest in the cycle.
- s_ready  out  1  queue can accept all three sources this cycle.
- s_tgt0..s_tgt2  in  6 each  target register.
- s_res0..s_res2  in  VALW each  result value.
- s_ip0..s_ip2  in  IPW each  instruction address.
- wr0..wr2  out  1 each  write enables to the register file.
- wa0..wa2  out  6 each  write addresses.
- i0..i2  out  VALW each  write data.
- ip0..ip2  out  IPW each  instruction address of the write.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): head, tail and count = 0; wr0..wr2 = 0; wa, i and ip outputs = 0; s_ready = 1; overflow = 0. Reset mid-operation discards all entries.
- s_ready = (DEPTH - count) >= 3. This is combinational from registered count only, never from s_valid.
- Enqueue at the rising edge when s_ready and any s_valid bit is set.
  - Sources with valid and tgt != 0 are compacted in source order (0, 1, 2) into consecutive slots starting at tail.
  - tail advances by the number written, modulo DEPTH.
  - Results targeting r0 are accepted and silently dropped; they consume no slot.
- s_valid while s_ready = 0: nothing enqueued and overflow is set (sticky until reset). Upstream is required to hold.
- Dequeue is evaluated combinationally from the registered state: n = min(count, 3) when stall = 0, otherwise n = 0.
  - Entry head+k (k < n) is registered onto channel k at the edge.
  - head advances by n, modulo DEPTH.
- Outputs are registered.
  - wrk = 1 only in the cycle following the edge at which entry k was dequeued. Unused channels drive wrk = 0, with wa/i/ip held at their previous values.
  - stall = 1 forces wr0..wr2 = 0 at the next edge.
- Latency: a result accepted at edge E is eligible to dequeue at edge E+1 and is visible on the wr outputs after edge E+1, assuming an empty queue and no stall. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: count_next = count + enq - n. Dequeue reads only entries present before the edge.
- Duplicate targets may be issued in one cycle. Program order is preserved by channel position, and the register file resolves the conflict.
- Wrap-around: all index arithmetic is modulo DEPTH. Slot selection for k = 0..2 wraps independently.
- flush = 1: at the edge, head = tail = count = 0 and wr0..wr2 = 0. Enqueue in the same cycle is discarded. flush has priority over stall and enqueue.
- count never exceeds DEPTH. An assertion fires if count_next > DEPTH.

Test Plan:
- Reset then single push (s_valid = 001, tgt0 = 5, res0 = 0x1234) → after edge E+1: wr = 001, wa0 = 5, i0 = 0x1234; count returns to 0.
- Push s_valid = 111 with tgts {3, 0, 7} → only 2 entries are queued (r0 dropped); wr = 011 with wa0 = 3, wa1 = 7.
- Hold stall = 1 while pushing 111 six times with DEPTH = 16 → count = 15 after 5 pushes and s_ready = 0. Sixth push held with s_valid asserted → overflow = 1, count stays 15. Release stall → drains 3/3/3/3/3 over 5 cycles in FIFO order.
- Wrap test: fill and drain repeatedly for 40 cycles with random valid patterns → output sequence matches the reference-model order exactly across head/tail wrap.
- Same target in one push (tgt0 = tgt1 = tgt2 = 9, res = 1, 2, 3) → channels 0, 1, 2 carry 1, 2, 3 with wa = 9 on all three.
- flush with 8 queued entries plus a simultaneous push → next cycle count = 0 and wr = 000. Assert rst_n low mid-drain → outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rfbw_wb_queue.sv
// Writeback queue in front of the register file: accepts up to three results per cycle
// in program order and issues up to three writes per cycle, oldest on channel 0.
module rfbw_wb_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned VALW  = 64,
  parameter int unsigned IPW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     stall,
  input  logic [2:0]               s_valid,
  output logic                     s_ready,
  input  logic [5:0]               s_tgt0,
  input  logic [5:0]               s_tgt1,
  input  logic [5:0]               s_tgt2,
  input  logic [VALW-1:0]          s_res0,
  input  logic [VALW-1:0]          s_res1,
  input  logic [VALW-1:0]          s_res2,
  input  logic [IPW-1:0]           s_ip0,
  input  logic [IPW-1:0]           s_ip1,
  input  logic [IPW-1:0]           s_ip2,
  output logic                     wr0,
  output logic                     wr1,
  output logic                     wr2,
  output logic [5:0]               wa0,
  output logic [5:0]               wa1,
  output logic [5:0]               wa2,
  output logic [VALW-1:0]          i0,
  output logic [VALW-1:0]          i1,
  output logic [VALW-1:0]          i2,
  output logic [IPW-1:0]           ip0,
  output logic [IPW-1:0]           ip1,
  output logic [IPW-1:0]           ip2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            r_overflow;

  logic [5:0]      r_mtgt [DEPTH];
  logic [VALW-1:0] r_mres [DEPTH];
  logic [IPW-1:0]  r_mip  [DEPTH];

  logic [2:0]      r_wr;
  logic [5:0]      r_wa [3];
  logic [VALW-1:0] r_i  [3];
  logic [IPW-1:0]  r_ip [3];

  logic [5:0]      w_src_tgt [3];
  logic [VALW-1:0] w_src_res [3];
  logic [IPW-1:0]  w_src_ip  [3];
  logic [2:0]      w_keep;
  logic            w_push;
  logic [1:0]      w_slot_off [3];
  logic [1:0]      w_n_enq;
  logic [1:0]      w_n_deq;
  logic [AW+1:0]   w_count_next;

  always_comb begin
    w_src_tgt[0] = s_tgt0;
    w_src_tgt[1] = s_tgt1;
    w_src_tgt[2] = s_tgt2;
    w_src_res[0] = s_res0;
    w_src_res[1] = s_res1;
    w_src_res[2] = s_res2;
    w_src_ip[0]  = s_ip0;
    w_src_ip[1]  = s_ip1;
    w_src_ip[2]  = s_ip2;
  end

  assign s_ready = (r_count <= (AW+1)'(DEPTH - 3));

  // Writes to r0 are accepted but never occupy a slot.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_keep[k] = s_valid[k] & (w_src_tgt[k] != 6'd0);
    end
  end

  assign w_push        = s_ready & (|s_valid) & ~flush;
  assign w_slot_off[0] = 2'd0;
  assign w_slot_off[1] = {1'b0, w_keep[0]};
  assign w_slot_off[2] = {1'b0, w_keep[0]} + {1'b0, w_keep[1]};
  assign w_n_enq       = w_push ? ({1'b0, w_keep[0]} + {1'b0, w_keep[1]} + {1'b0, w_keep[2]})
                                : 2'd0;
  assign w_n_deq       = stall ? 2'd0
                       : (r_count >= (AW+1)'(3)) ? 2'd3 : r_count[1:0];
  assign w_count_next  = flush ? '0
                       : (AW+2)'(r_count) + (AW+2)'(w_n_enq) - (AW+2)'(w_n_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_wr       <= '0;
      for (int k = 0; k < 3; k++) begin
        r_wa[k] <= '0;
        r_i[k]  <= '0;
        r_ip[k] <= '0;
      end
    end else begin
      r_overflow <= r_overflow | ((|s_valid) & ~s_ready);
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_wr    <= '0;
      end else begin
        r_head  <= r_head + AW'(w_n_deq);
        r_tail  <= r_tail + AW'(w_n_enq);
        r_count <= w_count_next[AW:0];
        // Idle channels keep their last address/data; only the enable drops.
        for (int k = 0; k < 3; k++) begin
          if (2'(k) < w_n_deq) begin
            r_wr[k] <= 1'b1;
            r_wa[k] <= r_mtgt[r_head + AW'(k)];
            r_i[k]  <= r_mres[r_head + AW'(k)];
            r_ip[k] <= r_mip[r_head + AW'(k)];
          end else begin
            r_wr[k] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < 3; k++) begin
        if (w_keep[k]) begin
          r_mtgt[r_tail + AW'(w_slot_off[k])] <= w_src_tgt[k];
          r_mres[r_tail + AW'(w_slot_off[k])] <= w_src_res[k];
          r_mip[r_tail + AW'(w_slot_off[k])]  <= w_src_ip[k];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (w_count_next <= (AW+2)'(DEPTH));
    end
  end
`endif

  assign wr0      = r_wr[0];
  assign wr1      = r_wr[1];
  assign wr2      = r_wr[2];
  assign wa0      = r_wa[0];
  assign wa1      = r_wa[1];
  assign wa2      = r_wa[2];
  assign i0       = r_i[0];
  assign i1       = r_i[1];
  assign i2       = r_i[2];
  assign ip0      = r_ip[0];
  assign ip1      = r_ip[1];
  assign ip2      = r_ip[2];
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_rfbw_wb_queue.sv
// Bench for rfbw_wb_queue: queue-based reference model checked every cycle, plus
// hand-computed expectations at key points of the directed sequence.
module tb_rfbw_wb_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned VALW  = 64;
  localparam int unsigned IPW   = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            stall = 1'b0;
  logic [2:0]      s_valid = 3'b000;
  logic            s_ready;
  logic [5:0]      s_tgt [3];
  logic [VALW-1:0] s_res [3];
  logic [IPW-1:0]  s_ip  [3];
  logic            wr0, wr1, wr2;
  logic [5:0]      wa0, wa1, wa2;
  logic [VALW-1:0] i0, i1, i2;
  logic [IPW-1:0]  ip0, ip1, ip2;
  logic [4:0]      count;
  logic            overflow;

  rfbw_wb_queue #(.DEPTH(DEPTH), .VALW(VALW), .IPW(IPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_tgt0(s_tgt[0]), .s_tgt1(s_tgt[1]), .s_tgt2(s_tgt[2]),
    .s_res0(s_res[0]), .s_res1(s_res[1]), .s_res2(s_res[2]),
    .s_ip0(s_ip[0]), .s_ip1(s_ip[1]), .s_ip2(s_ip[2]),
    .wr0(wr0), .wr1(wr1), .wr2(wr2),
    .wa0(wa0), .wa1(wa1), .wa2(wa2),
    .i0(i0), .i1(i1), .i2(i2),
    .ip0(ip0), .ip1(ip1), .ip2(ip2),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int ip_seq = 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of results in program order.
  typedef struct packed {
    logic [5:0]      tgt;
    logic [VALW-1:0] res;
    logic [IPW-1:0]  ip;
  } ent_t;

  ent_t            mq[$];
  ent_t            m_e;
  logic [2:0]      m_wr = '0;
  logic [5:0]      m_wa [3] = '{default: '0};
  logic [VALW-1:0] m_i  [3] = '{default: '0};
  logic [IPW-1:0]  m_ip [3] = '{default: '0};
  bit              m_ovf = 1'b0;
  bit              m_rdy;
  int              m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_wr  = '0;
      for (int k = 0; k < 3; k++) begin
        m_wa[k] = '0; m_i[k] = '0; m_ip[k] = '0;
      end
    end else begin
      m_rdy = (DEPTH - mq.size()) >= 3;
      m_n   = stall ? 0 : ((mq.size() < 3) ? mq.size() : 3);
      if (|s_valid && !m_rdy) m_ovf = 1'b1;
      if (flush) begin
        m_wr = '0;
        mq.delete();
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (k < m_n) begin
            m_e     = mq.pop_front();
            m_wr[k] = 1'b1;
            m_wa[k] = m_e.tgt;
            m_i[k]  = m_e.res;
            m_ip[k] = m_e.ip;
          end else begin
            m_wr[k] = 1'b0;
          end
        end
        if (m_rdy) begin
          for (int k = 0; k < 3; k++) begin
            if (s_valid[k] && s_tgt[k] != 6'd0) mq.push_back('{s_tgt[k], s_res[k], s_ip[k]});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("wr", {61'd0, wr2, wr1, wr0}, {61'd0, m_wr});
      chk("wa0", 64'(wa0), 64'(m_wa[0]));
      chk("wa1", 64'(wa1), 64'(m_wa[1]));
      chk("wa2", 64'(wa2), 64'(m_wa[2]));
      chk("i0", i0, m_i[0]);
      chk("i1", i1, m_i[1]);
      chk("i2", i2, m_i[2]);
      chk("ip0", 64'(ip0), 64'(m_ip[0]));
      chk("ip1", 64'(ip1), 64'(m_ip[1]));
      chk("ip2", 64'(ip2), 64'(m_ip[2]));
      chk("count", 64'(count), 64'(mq.size()));
      chk("s_ready", 64'(s_ready), 64'((DEPTH - mq.size()) >= 3));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [5:0] t0, input logic [5:0] t1,
                       input logic [5:0] t2, input logic [63:0] r0, input logic [63:0] r1,
                       input logic [63:0] r2);
    s_valid  = v;
    s_tgt[0] = t0; s_tgt[1] = t1; s_tgt[2] = t2;
    s_res[0] = r0; s_res[1] = r1; s_res[2] = r2;
    for (int k = 0; k < 3; k++) begin
      s_ip[k] = 32'(ip_seq);
      ip_seq++;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_tgt[k] = '0; s_res[k] = '0; s_ip[k] = '0;
    end
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_wr", {61'd0, wr2, wr1, wr0}, 64'd0);
    chk("rst_wa0", 64'(wa0), 64'd0);
    chk("rst_i2", i2, 64'd0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Single push, visible one edge after acceptance.
    drive(3'b001, 6'd5, 6'd0, 6'd0, 64'h1234, 64'd0, 64'd0);
    tick();
    s_valid = 3'b000;
    chk("t1_count_e", 64'(count), 64'd1);
    tick();
    chk("t1_wr", {61'd0, wr2, wr1, wr0}, 64'b001);
    chk("t1_wa0", 64'(wa0), 64'd5);
    chk("t1_i0", i0, 64'h1234);
    chk("t1_count", 64'(count), 64'd0);

    // r0 target dropped and compacted.
    drive(3'b111, 6'd3, 6'd0, 6'd7, 64'hA, 64'hB, 64'hC);
    tick();
    s_valid = 3'b000;
    chk("t2_count", 64'(count), 64'd2);
    tick();
    chk("t2_wr", {61'd0, wr2, wr1, wr0}, 64'b011);
    chk("t2_wa0", 64'(wa0), 64'd3);
    chk("t2_wa1", 64'(wa1), 64'd7);
    chk("t2_i1", i1, 64'hC);

    // Fill under stall, overflow on a held push, then drain.
    stall = 1'b1;
    for (int p = 0; p < 5; p++) begin
      drive(3'b111, 6'(3*p+1), 6'(3*p+2), 6'(3*p+3), 64'(100+3*p), 64'(101+3*p), 64'(102+3*p));
      tick();
    end
    s_valid = 3'b000;
    chk("t3_count15", 64'(count), 64'd15);
    chk("t3_notready", 64'(s_ready), 64'd0);
    chk("t3_noovf", 64'(overflow), 64'd0);
    drive(3'b111, 6'd40, 6'd41, 6'd42, 64'd1, 64'd2, 64'd3);
    tick();
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_hold15", 64'(count), 64'd15);
    tick();
    s_valid = 3'b000;
    stall = 1'b0;
    for (int d = 0; d < 5; d++) begin
      tick();
      chk("t3_drain_wr", {61'd0, wr2, wr1, wr0}, 64'b111);
      if (d == 0) begin
        chk("t3_first_wa0", 64'(wa0), 64'd1);
        chk("t3_first_wa2", 64'(wa2), 64'd3);
      end
    end
    chk("t3_last_wa2", 64'(wa2), 64'd15);
    chk("t3_last_i2", i2, 64'd114);
    chk("t3_empty", 64'(count), 64'd0);

    // Same target on all three sources.
    drive(3'b111, 6'd9, 6'd9, 6'd9, 64'd1, 64'd2, 64'd3);
    tick();
    s_valid = 3'b000;
    tick();
    chk("t5_wr", {61'd0, wr2, wr1, wr0}, 64'b111);
    chk("t5_wa0", 64'(wa0), 64'd9);
    chk("t5_wa1", 64'(wa1), 64'd9);
    chk("t5_wa2", 64'(wa2), 64'd9);
    chk("t5_i0", i0, 64'd1);
    chk("t5_i1", i1, 64'd2);
    chk("t5_i2", i2, 64'd3);

    // Random fill/drain across head/tail wrap.
    for (int c = 0; c < 40; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ((DEPTH - mq.size()) >= 3) begin
        drive(3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
              ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
              ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        s_valid = 3'b000;
      end
      tick();
    end
    s_valid = 3'b000;
    stall = 1'b0;
    repeat (8) tick();
    chk("t4_drained", 64'(count), 64'd0);

    // Flush with 8 queued entries and a simultaneous push.
    stall = 1'b1;
    drive(3'b111, 6'd10, 6'd11, 6'd12, 64'd10, 64'd11, 64'd12);
    tick();
    drive(3'b111, 6'd13, 6'd14, 6'd15, 64'd13, 64'd14, 64'd15);
    tick();
    drive(3'b011, 6'd16, 6'd17, 6'd0, 64'd16, 64'd17, 64'd0);
    tick();
    chk("t6_count8", 64'(count), 64'd8);
    flush = 1'b1;
    drive(3'b111, 6'd20, 6'd21, 6'd22, 64'd20, 64'd21, 64'd22);
    tick();
    flush = 1'b0;
    s_valid = 3'b000;
    stall = 1'b0;
    chk("t6_flush_count", 64'(count), 64'd0);
    chk("t6_flush_wr", {61'd0, wr2, wr1, wr0}, 64'b000);
    tick();
    chk("t6_after_wr", {61'd0, wr2, wr1, wr0}, 64'b000);

    // Asynchronous reset in the middle of a drain.
    for (int p = 0; p < 3; p++) begin
      drive(3'b111, 6'd30, 6'd31, 6'd32, 64'd30, 64'd31, 64'd32);
      tick();
    end
    s_valid = 3'b000;
    chk("t7_busy_wr", {61'd0, wr2, wr1, wr0}, 64'b111);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_wr", {61'd0, wr2, wr1, wr0}, 64'b000);
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_wa0", 64'(wa0), 64'd0);
    chk("t7_rst_i0", i0, 64'd0);
    chk("t7_rst_ip0", 64'(ip0), 64'd0);
    chk("t7_rst_ready", 64'(s_ready), 64'd1);
    chk("t7_rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
